// File: rtl/mmc3_irq_unit.sv
// MMC3-style scanline IRQ unit: filtered PPU A12 rising edges clock an
// 8-bit reloadable down-counter that raises an active-low IRQ at zero.
module mmc3_irq_unit #(
    parameter int A12_FILTER = 3,
    parameter bit ALT_IRQ    = 1'b0
) (
    input  logic        m2,
    input  logic        rst_n,
    input  logic        mapper_sel,
    input  logic        romsel,
    input  logic        cpu_rw_in,
    input  logic [14:0] cpu_addr_in,
    input  logic [7:0]  cpu_data_in,
    input  logic        ppu_a12,
    output logic        irq,
    output logic [7:0]  irq_counter
);

    localparam int LW = (A12_FILTER < 1) ? 1 : $clog2(A12_FILTER + 1);
    localparam logic [LW-1:0] LOW_MAX = LW'(A12_FILTER);

    logic          r_a12_meta;
    logic          r_a12_s;
    logic          r_a12_prev;
    logic [LW-1:0] r_low_cnt;
    logic [7:0]    r_latch;
    logic [7:0]    r_counter;
    logic          r_reload;
    logic          r_enable;
    logic          r_pending;
    logic          r_irq;

    logic          w_write;
    logic [2:0]    w_code;
    logic          w_event;
    logic [7:0]    w_latch_next;
    logic [7:0]    w_counter_next;
    logic          w_reload_next;
    logic          w_enable_next;
    logic          w_pending_next;
    logic [11:0]   w_unused_addr;

    assign w_write       = mapper_sel & ~romsel & ~cpu_rw_in;
    assign w_code        = {cpu_addr_in[14], cpu_addr_in[13], cpu_addr_in[0]};
    assign w_unused_addr = cpu_addr_in[12:1];
    assign w_event       = r_a12_s & ~r_a12_prev & (r_low_cnt >= LOW_MAX);

    // The event sees pre-write state; a same-edge register write then wins.
    always_comb begin
        w_latch_next   = r_latch;
        w_counter_next = r_counter;
        w_reload_next  = r_reload;
        w_enable_next  = r_enable;
        w_pending_next = r_pending;

        if (w_event) begin
            if ((r_counter == 8'd0) || r_reload) begin
                w_counter_next = r_latch;
                w_reload_next  = 1'b0;
            end else begin
                w_counter_next = r_counter - 8'd1;
            end
            if ((w_counter_next == 8'd0) && r_enable &&
                (!ALT_IRQ || (r_counter != 8'd0) || r_reload)) begin
                w_pending_next = 1'b1;
            end
        end

        if (w_write) begin
            case (w_code)
                3'b100: w_latch_next = cpu_data_in;
                3'b101: begin
                    w_counter_next = 8'd0;
                    w_reload_next  = 1'b1;
                end
                3'b110: begin
                    w_enable_next  = 1'b0;
                    w_pending_next = 1'b0;
                end
                3'b111: w_enable_next = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge m2) begin
        if (!rst_n) begin
            r_a12_meta <= 1'b0;
            r_a12_s    <= 1'b0;
            r_a12_prev <= 1'b0;
            r_low_cnt  <= '0;
        end else begin
            r_a12_meta <= ppu_a12;
            r_a12_s    <= r_a12_meta;
            r_a12_prev <= r_a12_s;
            if (r_a12_s) begin
                r_low_cnt <= '0;
            end else if (r_low_cnt < LOW_MAX) begin
                r_low_cnt <= r_low_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge m2) begin
        if (!rst_n) begin
            r_latch   <= 8'd0;
            r_counter <= 8'd0;
            r_reload  <= 1'b0;
            r_enable  <= 1'b0;
            r_pending <= 1'b0;
            r_irq     <= 1'b1;
        end else begin
            r_latch   <= w_latch_next;
            r_counter <= w_counter_next;
            r_reload  <= w_reload_next;
            r_enable  <= w_enable_next;
            r_pending <= w_pending_next;
            r_irq     <= ~w_pending_next;
        end
    end

    assign irq         = r_irq;
    assign irq_counter = r_counter;

endmodule

// File: tb/tb_mmc3_irq_unit.sv
// Directed bench for mmc3_irq_unit; drives a new-style and an old-style
// instance from the same bus and A12 stimulus.
module tb_mmc3_irq_unit;

    logic        m2 = 1'b0;
    logic        rstN;
    logic        mapperSel;
    logic        romsel;
    logic        cpuRw;
    logic [14:0] cpuAddr;
    logic [7:0]  cpuData;
    logic        ppuA12;
    logic        irqNew;
    logic [7:0]  counterNew;
    logic        irqOld;
    logic [7:0]  counterOld;

    int checks = 0;
    int errors = 0;

    always #5 m2 = ~m2;

    mmc3_irq_unit #(.A12_FILTER(3), .ALT_IRQ(1'b0)) dutNew (
        .m2(m2), .rst_n(rstN), .mapper_sel(mapperSel), .romsel(romsel),
        .cpu_rw_in(cpuRw), .cpu_addr_in(cpuAddr), .cpu_data_in(cpuData),
        .ppu_a12(ppuA12), .irq(irqNew), .irq_counter(counterNew)
    );

    mmc3_irq_unit #(.A12_FILTER(3), .ALT_IRQ(1'b1)) dutOld (
        .m2(m2), .rst_n(rstN), .mapper_sel(mapperSel), .romsel(romsel),
        .cpu_rw_in(cpuRw), .cpu_addr_in(cpuAddr), .cpu_data_in(cpuData),
        .ppu_a12(ppuA12), .irq(irqOld), .irq_counter(counterOld)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge m2);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One bus cycle; code is {A14,A13,A0}, the write lands on the next edge.
    task automatic applyStimulus(input logic [2:0] code, input logic [7:0] data,
                                 input logic sel, input logic rs);
        logic [2:0] c;
        c         = code;
        cpuAddr   = {c[2], c[1], 12'h000, c[0]};
        cpuData   = data;
        mapperSel = sel;
        romsel    = rs;
        cpuRw     = 1'b0;
        tick(1);
        mapperSel = 1'b1;
        romsel    = 1'b1;
        cpuRw     = 1'b1;
    endtask

    task automatic a12Pulse(input int lowTicks, input int highTicks);
        ppuA12 = 1'b0;
        tick(lowTicks);
        ppuA12 = 1'b1;
        tick(highTicks);
    endtask

    initial begin
        rstN = 1'b0; mapperSel = 1'b1; romsel = 1'b1; cpuRw = 1'b1;
        cpuAddr = '0; cpuData = '0; ppuA12 = 1'b0;
        tick(3);
        checkOutput("reset_irq", {7'd0, irqNew}, 8'd1);
        checkOutput("reset_counter", counterNew, 8'd0);
        checkOutput("reset_irq_old", {7'd0, irqOld}, 8'd1);
        rstN = 1'b1;
        tick(2);

        applyStimulus(3'b100, 8'd3, 1'b1, 1'b0);
        applyStimulus(3'b101, 8'd0, 1'b1, 1'b0);
        applyStimulus(3'b111, 8'd0, 1'b1, 1'b0);
        checkOutput("setup_counter", counterNew, 8'd0);

        a12Pulse(3, 4);
        checkOutput("event1_counter", counterNew, 8'd3);
        a12Pulse(4, 4);
        checkOutput("event2_counter", counterNew, 8'd2);
        a12Pulse(2, 4);
        checkOutput("short_low_counter", counterNew, 8'd2);
        checkOutput("short_low_irq", {7'd0, irqNew}, 8'd1);
        a12Pulse(3, 4);
        checkOutput("event3_counter", counterNew, 8'd1);

        ppuA12 = 1'b0;
        tick(3);
        ppuA12 = 1'b1;
        tick(2);
        checkOutput("pre_event4_counter", counterNew, 8'd1);
        checkOutput("pre_event4_irq", {7'd0, irqNew}, 8'd1);
        tick(1);
        checkOutput("event4_counter", counterNew, 8'd0);
        checkOutput("event4_irq", {7'd0, irqNew}, 8'd0);
        checkOutput("event4_irq_old", {7'd0, irqOld}, 8'd0);
        tick(1);

        applyStimulus(3'b111, 8'd0, 1'b1, 1'b0);
        checkOutput("e001_keeps_irq", {7'd0, irqNew}, 8'd0);
        applyStimulus(3'b110, 8'd0, 1'b1, 1'b0);
        checkOutput("e000_clears_irq", {7'd0, irqNew}, 8'd1);
        a12Pulse(3, 4);
        checkOutput("disabled_reload", counterNew, 8'd3);
        checkOutput("disabled_irq", {7'd0, irqNew}, 8'd1);

        applyStimulus(3'b111, 8'd0, 1'b1, 1'b0);
        a12Pulse(3, 4);
        a12Pulse(3, 4);
        checkOutput("pre_collide_counter", counterNew, 8'd1);
        ppuA12 = 1'b0;
        tick(3);
        ppuA12 = 1'b1;
        tick(2);
        applyStimulus(3'b110, 8'd0, 1'b1, 1'b0);
        checkOutput("e000_collide_counter", counterNew, 8'd0);
        checkOutput("e000_collide_irq", {7'd0, irqNew}, 8'd1);
        tick(2);
        applyStimulus(3'b100, 8'd0, 1'b1, 1'b0);
        a12Pulse(3, 4);
        checkOutput("enable_cleared_irq", {7'd0, irqNew}, 8'd1);

        applyStimulus(3'b100, 8'd5, 1'b1, 1'b0);
        a12Pulse(3, 4);
        checkOutput("latch5_reload", counterNew, 8'd5);
        ppuA12 = 1'b0;
        tick(3);
        ppuA12 = 1'b1;
        tick(2);
        applyStimulus(3'b101, 8'd0, 1'b1, 1'b0);
        checkOutput("c001_collide_counter", counterNew, 8'd0);
        tick(2);
        a12Pulse(3, 4);
        checkOutput("c001_collide_reload", counterNew, 8'd5);

        applyStimulus(3'b101, 8'd0, 1'b0, 1'b0);
        checkOutput("unselected_write", counterNew, 8'd5);
        applyStimulus(3'b101, 8'd0, 1'b1, 1'b1);
        checkOutput("romsel_high_write", counterNew, 8'd5);

        applyStimulus(3'b110, 8'd0, 1'b1, 1'b0);
        applyStimulus(3'b100, 8'd0, 1'b1, 1'b0);
        applyStimulus(3'b101, 8'd0, 1'b1, 1'b0);
        applyStimulus(3'b111, 8'd0, 1'b1, 1'b0);
        a12Pulse(3, 4);
        checkOutput("latch0_first_irq", {7'd0, irqNew}, 8'd0);
        checkOutput("latch0_first_irq_old", {7'd0, irqOld}, 8'd0);
        checkOutput("latch0_counter", counterNew, 8'd0);
        applyStimulus(3'b110, 8'd0, 1'b1, 1'b0);
        applyStimulus(3'b111, 8'd0, 1'b1, 1'b0);
        a12Pulse(3, 4);
        checkOutput("latch0_second_irq", {7'd0, irqNew}, 8'd0);
        checkOutput("latch0_second_irq_old", {7'd0, irqOld}, 8'd1);

        applyStimulus(3'b100, 8'd5, 1'b1, 1'b0);
        a12Pulse(3, 4);
        checkOutput("pre_reset_counter", counterNew, 8'd5);
        checkOutput("pre_reset_irq", {7'd0, irqNew}, 8'd0);
        rstN = 1'b0;
        tick(1);
        checkOutput("midrun_reset_irq", {7'd0, irqNew}, 8'd1);
        checkOutput("midrun_reset_counter", counterNew, 8'd0);
        rstN = 1'b1;
        applyStimulus(3'b111, 8'd0, 1'b1, 1'b0);
        a12Pulse(3, 4);
        checkOutput("post_reset_latch_counter", counterNew, 8'd0);
        checkOutput("post_reset_latch_irq", {7'd0, irqNew}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
